// File: rtl/rate_spike_encoder.sv
// ---------------------------------------------------------------------------
// rate_spike_encoder
//
// Rate (Bernoulli) spike encoder. A small buffer of 8-bit pixel intensities is
// turned into spike trains: for every timestep and every pixel the spike bit
// is (pixel > rand_i), where rand_i is a free-running LFSR byte. Results are
// streamed one (timestep, pixel) pair per valid/ready handshake, step-major,
// pixel index ascending.
//
// Optional feature macro: RATE_ENC_SPIKE_COUNT_EN
//   When defined, adds spike_count_o: a saturating count of accepted results
//   with spike_o=1, cleared on an accepted start and held after the run.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   rand_i         random byte, sampled only on output-load cycles
//   pix_we_i       pixel write strobe (honoured only while idle)
//   pix_addr_i     pixel write address
//   pix_data_i     pixel write data
//   start_i        single-cycle start pulse (honoured only while idle)
//   num_steps_i    number of timesteps, sampled with start_i
//   busy_o         high whenever a run is in progress (state != IDLE)
//   spike_valid_o  output register holds a result
//   spike_ready_i  downstream accepts the result
//   spike_o        spike bit
//   spike_idx_o    pixel index of the result
//   spike_step_o   timestep of the result
//   spike_count_o  (optional) saturating count of accepted spikes
//   done_o         one-cycle pulse when a run completes
// ---------------------------------------------------------------------------
module rate_spike_encoder #(
  parameter int NUM_PIXELS = 16,
  parameter int IDX_W      = 4,
  parameter int STEP_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rand_i,
  input  logic              pix_we_i,
  input  logic [IDX_W-1:0]  pix_addr_i,
  input  logic [7:0]        pix_data_i,
  input  logic              start_i,
  input  logic [STEP_W-1:0] num_steps_i,
  output logic              busy_o,
  output logic              spike_valid_o,
  input  logic              spike_ready_i,
  output logic              spike_o,
  output logic [IDX_W-1:0]  spike_idx_o,
  output logic [STEP_W-1:0] spike_step_o,
`ifdef RATE_ENC_SPIKE_COUNT_EN
  output logic [15:0]       spike_count_o,
`endif
  output logic              done_o
);

  // state | meaning
  // IDLE  | waiting for start; pixel buffer writable
  // RUN   | producing one result per free output slot
  // DRAIN | last pair loaded, waiting for it to be accepted
  // DONE  | run finished; done_o pulses on the way back to IDLE
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PIXELS - 1);

  state_t            state_q;
  logic [7:0]        pixel_q [NUM_PIXELS];
  logic [IDX_W-1:0]  idx_q;
  logic [STEP_W-1:0] step_q;
  logic [STEP_W-1:0] steps_q;

  logic load;
  logic last_pair;
  logic spike_bit;
  logic start_accept;

  // The output slot is free when empty or being emptied this cycle.
  assign load         = !spike_valid_o || spike_ready_i;
  // steps_q is never 0 while in RUN, so steps_q-1 cannot underflow here.
  assign last_pair    = (step_q == steps_q - STEP_W'(1)) && (idx_q == IDX_LAST);
  assign spike_bit    = pixel_q[idx_q] > rand_i;
  assign start_accept = (state_q == S_IDLE) && start_i;
  assign busy_o       = (state_q != S_IDLE);

  // Pixel buffer: writable only while idle, frozen for the whole run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_PIXELS; i++) begin
        pixel_q[i] <= 8'h00;
      end
    end else if ((state_q == S_IDLE) && pix_we_i) begin
      pixel_q[pix_addr_i] <= pix_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      step_q        <= '0;
      steps_q       <= '0;
      spike_valid_o <= 1'b0;
      spike_o       <= 1'b0;
      spike_idx_o   <= '0;
      spike_step_o  <= '0;
      done_o        <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            steps_q <= num_steps_i;
            idx_q   <= '0;
            step_q  <= '0;
            state_q <= (num_steps_i == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (load) begin
            spike_o       <= spike_bit;
            spike_idx_o   <= idx_q;
            spike_step_o  <= step_q;
            spike_valid_o <= 1'b1;
            // Counters stop on the last pair so the step counter never wraps,
            // even for the maximum step count.
            if (last_pair) begin
              state_q <= S_DRAIN;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
              if (idx_q == IDX_LAST) begin
                step_q <= step_q + STEP_W'(1);
              end
            end
          end
        end
        S_DRAIN: begin
          if (load) begin
            spike_valid_o <= 1'b0;
            state_q       <= S_DONE;
          end
        end
        S_DONE: begin
          done_o  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef RATE_ENC_SPIKE_COUNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spike_count_o <= 16'h0000;
    end else if (start_accept) begin
      spike_count_o <= 16'h0000;
    end else if (spike_valid_o && spike_ready_i && spike_o &&
                 (spike_count_o != 16'hFFFF)) begin
      spike_count_o <= spike_count_o + 16'h0001;
    end
  end
`else
  // Without the counter the start-accept term has no consumer.
  logic unused_start_accept;
  assign unused_start_accept = start_accept;
`endif

endmodule

// File: tb/tb_rate_spike_encoder.sv
module tb_rate_spike_encoder;
  localparam int NP = 16;
  localparam int IW = 4;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    rand_b = 8'h00;
  logic          pix_we = 1'b0;
  logic [IW-1:0] pix_addr = '0;
  logic [7:0]    pix_data = 8'h00;
  logic          start = 1'b0;
  logic [SW-1:0] num_steps = '0;
  logic          spike_ready = 1'b0;
  logic          busy, valid, spike, done;
  logic [IW-1:0] sidx;
  logic [SW-1:0] sstep;
`ifdef RATE_ENC_SPIKE_COUNT_EN
  logic [15:0]   scount;
`endif

  always #5 clk = ~clk;

  rate_spike_encoder #(.NUM_PIXELS(NP), .IDX_W(IW), .STEP_W(SW)) dut (
    .clk(clk), .rst(rst), .rand_i(rand_b),
    .pix_we_i(pix_we), .pix_addr_i(pix_addr), .pix_data_i(pix_data),
    .start_i(start), .num_steps_i(num_steps),
    .busy_o(busy), .spike_valid_o(valid), .spike_ready_i(spike_ready),
    .spike_o(spike), .spike_idx_o(sidx), .spike_step_o(sstep),
`ifdef RATE_ENC_SPIKE_COUNT_EN
    .spike_count_o(scount),
`endif
    .done_o(done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model + compare (one process) ----------------
  // The run is a flat sequence of k = 0 .. steps*NP-1 results; result k is
  // (step k/NP, pixel k%NP). A new result enters the output slot on any edge
  // where the slot is empty or being accepted.
  logic [7:0] pix_m [NP];
  int   phase;        // 0 idle, 1 results outstanding, 2 finishing
  int   k, total;
  logic e_valid, e_spike, e_done, e_busy;
  int   e_idx, e_step, e_cnt;
  logic          p_valid = 1'b0;
  logic          p_spike = 1'b0;
  logic [IW-1:0] p_idx = '0;
  logic [SW-1:0] p_step = '0;
  int   log_idx[$], log_step[$], log_spk[$];
  int   n_done = 0, n_valid = 0;

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NP; i++) pix_m[i] = 8'h00;
      phase = 0; k = 0; total = 0;
      e_valid = 1'b0; e_spike = 1'b0; e_done = 1'b0; e_busy = 1'b0;
      e_idx = 0; e_step = 0; e_cnt = 0;
      chk("rst_valid", int'(valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_spike", int'(spike), 0);
      chk("rst_idx", int'(sidx), 0);
      chk("rst_step", int'(sstep), 0);
`ifdef RATE_ENC_SPIKE_COUNT_EN
      chk("rst_count", int'(scount), 0);
`endif
    end else begin
      if (p_valid && spike_ready) begin
        log_idx.push_back(int'(p_idx));
        log_step.push_back(int'(p_step));
        log_spk.push_back(int'(p_spike));
      end
      e_done = (phase == 2);
      if (phase == 0) begin
        if (pix_we) pix_m[pix_addr] = pix_data;
        if (start) begin
          e_cnt = 0;
          k = 0;
          total = int'(num_steps) * NP;
          phase = (num_steps == 0) ? 2 : 1;
        end
      end else if (phase == 1) begin
        if (e_valid && spike_ready && e_spike && e_cnt < 65535) e_cnt++;
        if (!e_valid || spike_ready) begin
          if (k < total) begin
            e_idx = k % NP;
            e_step = k / NP;
            e_spike = pix_m[e_idx] > rand_b;
            e_valid = 1'b1;
            k++;
          end else begin
            e_valid = 1'b0;
            phase = 2;
          end
        end
      end else begin
        phase = 0;
      end
      e_busy = (phase != 0);
      chk("valid", int'(valid), int'(e_valid));
      chk("busy", int'(busy), int'(e_busy));
      chk("done", int'(done), int'(e_done));
      if (e_valid) begin
        chk("spike", int'(spike), int'(e_spike));
        chk("idx", int'(sidx), e_idx);
        chk("step", int'(sstep), e_step);
      end
`ifdef RATE_ENC_SPIKE_COUNT_EN
      chk("count", int'(scount), e_cnt);
`endif
      if (done) n_done++;
      if (valid) n_valid++;
    end
    p_valid = valid; p_spike = spike; p_idx = sidx; p_step = sstep;
  end

  // ---------------- stimulus ----------------
  logic       rand_rnd = 1'b1;
  logic [7:0] rand_fix = 8'h00;
  int         rdy_mode = 1;   // 0 low, 1 high, 2 random

  task automatic drive_free();
    rand_b = rand_rnd ? 8'($urandom) : rand_fix;
    spike_ready = (rdy_mode == 1) || (rdy_mode == 2 && $urandom_range(0, 9) < 7);
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
    drive_free();
  endtask

  task automatic set_modes(input logic rnd, input logic [7:0] val, input int rm);
    rand_rnd = rnd; rand_fix = val; rdy_mode = rm;
    drive_free();
  endtask

  task automatic write_pix(input int a, input logic [7:0] d);
    pix_we = 1'b1; pix_addr = IW'(a); pix_data = d;
    cyc();
    pix_we = 1'b0;
  endtask

  task automatic start_run(input int n);
    num_steps = SW'(n); start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input logic junk);
    int d0 = n_done;
    int i = 0;
    while (n_done == d0 && i < 20000) begin
      cyc();
      i++;
      if (junk && n_done == d0) begin
        pix_we = ($urandom_range(0, 3) == 0);
        pix_addr = IW'($urandom); pix_data = 8'($urandom);
        start = ($urandom_range(0, 7) == 0);
        num_steps = SW'($urandom_range(0, 5));
      end
    end
    pix_we = 1'b0; start = 1'b0;
    chk({name, "_finished"}, int'(n_done > d0), 1);
  endtask

  function automatic int spk_sum(input int from);
    int s = 0;
    for (int i = from; i < log_spk.size(); i++) s += log_spk[i];
    return s;
  endfunction

  initial begin
    int l0, v0, d0, h;
    // Reset held with arbitrary activity on the inputs.
    set_modes(1'b1, 8'h00, 2);
    repeat (4) begin
      cyc();
      pix_we = 1'($urandom); pix_addr = IW'($urandom); pix_data = 8'($urandom);
      start = 1'($urandom); num_steps = SW'($urandom);
    end
    chk("hold_rst_valid", int'(valid), 0);
    chk("hold_rst_busy", int'(busy), 0);
    cyc();
    pix_we = 1'b0; start = 1'b0; num_steps = '0;
    rst = 1'b1;
    cyc();

    // Single pixel at 0x80 against rand 0x7F: only index 3 spikes.
    set_modes(1'b0, 8'h7F, 1);
    write_pix(3, 8'h80);
    l0 = log_spk.size(); d0 = n_done;
    start_run(1);
    wait_done("t1", 1'b0);
    repeat (3) cyc();
    chk("t1_results", log_spk.size() - l0, 16);
    chk("t1_done_pulses", n_done - d0, 1);
    for (int i = 0; i < 16; i++) begin
      if (l0 + i < log_spk.size()) begin
        chk("t1_order_idx", log_idx[l0 + i], i);
        chk("t1_order_step", log_step[l0 + i], 0);
        chk("t1_spike", log_spk[l0 + i], (i == 3) ? 1 : 0);
      end
    end

    // All pixels 0xFF: rand 0xFF never spikes, rand 0xFE always spikes.
    for (int i = 0; i < NP; i++) write_pix(i, 8'hFF);
    set_modes(1'b0, 8'hFF, 1);
    l0 = log_spk.size(); v0 = n_valid;
    start_run(2);
    wait_done("t2a", 1'b0);
    chk("t2a_results", log_spk.size() - l0, 32);
    chk("t2a_valid_cycles", n_valid - v0, 32);
    chk("t2a_spikes", spk_sum(l0), 0);
    set_modes(1'b0, 8'hFE, 1);
    l0 = log_spk.size();
    start_run(2);
    wait_done("t2b", 1'b0);
    chk("t2b_results", log_spk.size() - l0, 32);
    chk("t2b_spikes", spk_sum(l0), 32);

    // Backpressure at result 7 with rand changing during the stall.
    for (int i = 0; i < NP; i++) write_pix(i, 8'($urandom));
    set_modes(1'b1, 8'h00, 1);
    l0 = log_spk.size();
    start_run(1);
    begin
      int t = 0;
      while (!(valid && sidx == 7) && t < 100) begin cyc(); t++; end
      chk("t3_reached_7", int'(valid && sidx == 7), 1);
    end
    h = int'(spike);
    set_modes(1'b1, 8'h00, 0);
    repeat (5) begin
      cyc();
      chk("t3_hold_valid", int'(valid), 1);
      chk("t3_hold_idx", int'(sidx), 7);
      chk("t3_hold_spike", int'(spike), h);
    end
    set_modes(1'b1, 8'h00, 1);
    wait_done("t3", 1'b0);
    chk("t3_results", log_spk.size() - l0, 16);
    for (int i = 0; i < 16; i++)
      if (l0 + i < log_idx.size()) chk("t3_order_idx", log_idx[l0 + i], i);

    // Zero timesteps: no results, done exactly two cycles after start.
    l0 = log_spk.size(); v0 = n_valid;
    start_run(0);
    chk("t4_busy_c1", int'(busy), 1);
    chk("t4_done_c1", int'(done), 0);
    cyc();
    chk("t4_done_c2", int'(done), 1);
    cyc();
    chk("t4_done_c3", int'(done), 0);
    chk("t4_no_valid", n_valid - v0, 0);

    // Writes and starts during a run are ignored.
    write_pix(0, 8'h00);
    set_modes(1'b1, 8'h00, 2);
    l0 = log_spk.size();
    start_run(3);
    repeat (3) cyc();
    pix_we = 1'b1; pix_addr = '0; pix_data = 8'hFF;
    start = 1'b1; num_steps = SW'(5);
    cyc();
    pix_we = 1'b0; start = 1'b0;
    wait_done("t5", 1'b0);
    chk("t5_results", log_spk.size() - l0, 48);
    for (int i = l0; i < log_idx.size(); i++)
      if (log_idx[i] == 0) chk("t5_pix0_no_spike", log_spk[i], 0);
    set_modes(1'b0, 8'h00, 1);
    l0 = log_spk.size();
    start_run(1);
    wait_done("t5b", 1'b0);
    if (l0 < log_spk.size()) chk("t5b_pix0_still_zero", log_spk[l0], 0);

    // Randomized runs with noise on writes/starts during the run.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < int'($urandom_range(1, 20)); i++)
        write_pix(int'($urandom_range(0, NP - 1)), 8'($urandom));
      set_modes(1'b1, 8'h00, 2);
      start_run(int'($urandom_range(1, 3)));
      wait_done("rand_run", 1'b1);
    end

    // Maximum step count: step counter reaches 254 without wrapping.
    set_modes(1'b1, 8'h00, 1);
    l0 = log_spk.size();
    start_run(255);
    wait_done("tmax", 1'b0);
    chk("tmax_results", log_spk.size() - l0, 4080);
    if (log_step.size() > 0) begin
      chk("tmax_last_step", log_step[log_step.size() - 1], 254);
      chk("tmax_last_idx", log_idx[log_idx.size() - 1], 15);
    end

`ifdef RATE_ENC_SPIKE_COUNT_EN
    for (int i = 0; i < NP; i++) write_pix(i, 8'hFF);
    set_modes(1'b0, 8'h00, 1);
    start_run(4);
    wait_done("tcnt", 1'b0);
    repeat (2) cyc();
    chk("tcnt_64", int'(scount), 64);
`endif

    // Abort mid-run: outputs clear at once, no done, pixels cleared.
    for (int i = 0; i < NP; i++) write_pix(i, 8'hFF);
    set_modes(1'b1, 8'h00, 2);
    start_run(3);
    repeat (10) cyc();
    d0 = n_done;
    rst = 1'b0;
    #1;
    chk("abort_valid", int'(valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_idx", int'(sidx), 0);
    chk("abort_step", int'(sstep), 0);
    repeat (3) cyc();
    rst = 1'b1;
    repeat (5) cyc();
    chk("abort_no_done", n_done - d0, 0);
    set_modes(1'b0, 8'h00, 1);
    l0 = log_spk.size();
    start_run(1);
    wait_done("tpost", 1'b0);
    chk("tpost_results", log_spk.size() - l0, 16);
    chk("tpost_pixels_cleared", spk_sum(l0), 0);

    repeat (3) cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1);
  end

endmodule
